// File: rtl/ov7670_capture.sv
// ov7670_capture
//
// Receives the camera's DVP timing (pclk / href / vsync plus an 8-bit data
// bus) in the system clock domain. It pairs bytes into RGB565 pixels and
// presents each pixel with its column, row and linear frame-buffer address.
// It sits between the camera pins and the frame-buffer write port.
//
// Ports:
//   clk_i          system clock, at least 4x the camera pixel clock
//   reset_i        synchronous active-high reset
//   cam_pclk_i     camera pixel clock, sampled as ordinary data
//   cam_vsync_i    camera vsync, high during vertical blank
//   cam_href_i     camera line-valid
//   cam_data_i     camera data byte
//   pixel_o        RGB565 pixel, first byte in [15:8], second in [7:0]
//   pixel_valid_o  one-cycle strobe qualifying pixel_o / x_o / y_o / addr_o
//   x_o, y_o       column and row of the strobed pixel
//   addr_o         linear frame-buffer address of the strobed pixel
//   frame_start_o  one-cycle strobe on the vsync falling edge opening a frame
//   frame_done_o   one-cycle strobe when a frame ends
//   error_o        sticky framing error flag, cleared only by reset_i
module ov7670_capture #(
    parameter int ACTIVE_COLUMNS = 640,
    parameter int ACTIVE_ROWS    = 480,
    localparam int XW = (ACTIVE_COLUMNS > 1) ? $clog2(ACTIVE_COLUMNS) : 1,
    localparam int YW = (ACTIVE_ROWS > 1) ? $clog2(ACTIVE_ROWS) : 1,
    localparam int AW = (ACTIVE_COLUMNS * ACTIVE_ROWS > 1) ?
                        $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS) : 1
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          cam_pclk_i,
    input  logic          cam_vsync_i,
    input  logic          cam_href_i,
    input  logic [7:0]    cam_data_i,
    output logic [15:0]   pixel_o,
    output logic          pixel_valid_o,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic [AW-1:0] addr_o,
    output logic          frame_start_o,
    output logic          frame_done_o,
    output logic          error_o
);

    typedef enum logic [1:0] {
        IDLE,
        VBLANK,
        FRAME,
        FINISH
    } state_t;

    state_t state, state_n;

    // Synchronizer: {pclk, href, vsync, data} travel through the same two
    // flops so they stay mutually aligned; a third flop on the control
    // lines provides edge detection.
    logic [10:0] sync1, sync2;
    logic        pclk_s3, href_s3, vsync_s3;

    logic        pclk_s2, href_s2, vsync_s2;
    logic [7:0]  data_s2;
    logic        pclk_rise, href_fall, vsync_rise, vsync_fall, capture;

    // Working counters and flags.
    logic [XW-1:0] x_cnt, x_n;
    logic [YW-1:0] y_cnt, y_n;
    logic [AW-1:0] addr_cnt, addr_n;
    logic          phase, phase_n;
    logic [7:0]    high_byte, high_n;
    logic          col_full, col_full_n;
    logic          row_full, row_full_n;
    logic          line_pix, line_pix_n;

    // Next values of the registered outputs.
    logic [15:0]   pixel_n;
    logic          pixel_valid_n;
    logic [XW-1:0] x_out_n;
    logic [YW-1:0] y_out_n;
    logic [AW-1:0] addr_out_n;
    logic          frame_start_n, frame_done_n, error_n;

    // Bring every camera signal into clk_i together.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            sync1    <= '0;
            sync2    <= '0;
            pclk_s3  <= 1'b0;
            href_s3  <= 1'b0;
            vsync_s3 <= 1'b0;
        end else begin
            sync1    <= {cam_pclk_i, cam_href_i, cam_vsync_i, cam_data_i};
            sync2    <= sync1;
            pclk_s3  <= sync2[10];
            href_s3  <= sync2[9];
            vsync_s3 <= sync2[8];
        end
    end

    assign pclk_s2    = sync2[10];
    assign href_s2    = sync2[9];
    assign vsync_s2   = sync2[8];
    assign data_s2    = sync2[7:0];
    assign pclk_rise  = pclk_s2 & ~pclk_s3;
    assign href_fall  = ~href_s2 & href_s3;
    assign vsync_rise = vsync_s2 & ~vsync_s3;
    assign vsync_fall = ~vsync_s2 & vsync_s3;
    // href already low on its falling-edge cycle, so a coincident pclk
    // rise is naturally not captured.
    assign capture    = pclk_rise & href_s2;

    // Next-state and datapath decisions. col_full / row_full remember that
    // the last column / row has been written, so x and y never need to
    // represent one-past-the-end and addr can never wrap inside a frame.
    always_comb begin
        state_n       = state;
        x_n           = x_cnt;
        y_n           = y_cnt;
        addr_n        = addr_cnt;
        phase_n       = phase;
        high_n        = high_byte;
        col_full_n    = col_full;
        row_full_n    = row_full;
        line_pix_n    = line_pix;
        pixel_n       = pixel_o;
        pixel_valid_n = 1'b0;
        x_out_n       = x_o;
        y_out_n       = y_o;
        addr_out_n    = addr_o;
        frame_start_n = 1'b0;
        frame_done_n  = 1'b0;
        error_n       = error_o;

        case (state)
            IDLE: begin
                // Whatever partial frame is in flight after reset is skipped.
                if (vsync_s2) begin
                    state_n = VBLANK;
                end
            end

            VBLANK: begin
                if (vsync_fall) begin
                    frame_start_n = 1'b1;
                    x_n           = '0;
                    y_n           = '0;
                    addr_n        = '0;
                    phase_n       = 1'b0;
                    col_full_n    = 1'b0;
                    row_full_n    = 1'b0;
                    line_pix_n    = 1'b0;
                    state_n       = FRAME;
                end
            end

            FRAME: begin
                if (capture) begin
                    if (!phase) begin
                        high_n  = data_s2;
                        phase_n = 1'b1;
                    end else begin
                        phase_n = 1'b0;
                        if (row_full || col_full) begin
                            error_n = 1'b1;
                        end else begin
                            pixel_n       = {high_byte, data_s2};
                            pixel_valid_n = 1'b1;
                            x_out_n       = x_cnt;
                            y_out_n       = y_cnt;
                            addr_out_n    = addr_cnt;
                            line_pix_n    = 1'b1;
                            addr_n        = addr_cnt + 1'b1;
                            if (x_cnt == XW'(ACTIVE_COLUMNS - 1)) begin
                                col_full_n = 1'b1;
                            end else begin
                                x_n = x_cnt + 1'b1;
                            end
                        end
                    end
                end

                // Line end: an odd byte count leaves a dangling high byte.
                if (href_fall) begin
                    if (phase) begin
                        error_n = 1'b1;
                    end
                    phase_n    = 1'b0;
                    x_n        = '0;
                    col_full_n = 1'b0;
                    line_pix_n = 1'b0;
                    if (line_pix) begin
                        if (y_cnt == YW'(ACTIVE_ROWS - 1)) begin
                            row_full_n = 1'b1;
                        end else begin
                            y_n = y_cnt + 1'b1;
                        end
                    end
                end

                // A pixel completed on the vsync edge goes out first, so the
                // done strobe is pushed one cycle later through FINISH.
                if (vsync_rise) begin
                    if (!row_full_n) begin
                        error_n = 1'b1;
                    end
                    if (capture && phase) begin
                        state_n = FINISH;
                    end else begin
                        frame_done_n = 1'b1;
                        state_n      = VBLANK;
                    end
                end
            end

            FINISH: begin
                frame_done_n = 1'b1;
                state_n      = VBLANK;
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state         <= IDLE;
            x_cnt         <= '0;
            y_cnt         <= '0;
            addr_cnt      <= '0;
            phase         <= 1'b0;
            high_byte     <= '0;
            col_full      <= 1'b0;
            row_full      <= 1'b0;
            line_pix      <= 1'b0;
            pixel_o       <= '0;
            pixel_valid_o <= 1'b0;
            x_o           <= '0;
            y_o           <= '0;
            addr_o        <= '0;
            frame_start_o <= 1'b0;
            frame_done_o  <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            state         <= state_n;
            x_cnt         <= x_n;
            y_cnt         <= y_n;
            addr_cnt      <= addr_n;
            phase         <= phase_n;
            high_byte     <= high_n;
            col_full      <= col_full_n;
            row_full      <= row_full_n;
            line_pix      <= line_pix_n;
            pixel_o       <= pixel_n;
            pixel_valid_o <= pixel_valid_n;
            x_o           <= x_out_n;
            y_o           <= y_out_n;
            addr_o        <= addr_out_n;
            frame_start_o <= frame_start_n;
            frame_done_o  <= frame_done_n;
            error_o       <= error_n;
        end
    end

endmodule
